rosc_odometer_sequencer: RTL and testbench

ROSC_ODOMETER_SEQUENCER -- requirements
Module: rosc_odometer_sequencer

---
 rtl/rosc_odo_pkg.sv | 14 +
 rtl/rosc_edge_counter.sv | 44 ++++
 rtl/rosc_odometer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_rosc_odometer_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rosc_odo_pkg.sv
// Shared definitions for the ring-oscillator odometer sequencer.
package rosc_odo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRESS,
    SETTLE,
    MEAS,
    REPORT
  } state_t;

  localparam int SETTLE_CYC = 4;

endpackage

// File: rtl/rosc_edge_counter.sv
// Synchronizes one asynchronous oscillator output and counts its rising edges,
// saturating at all-ones; ovf marks that at least one edge was dropped.
module rosc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [1:0]       sync_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             rise;

  assign rise  = sync_reg[1] & ~prev_reg;
  assign count = count_reg;
  assign ovf   = ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      prev_reg <= sync_reg[1];
      if (clr) begin
        count_reg <= '0;
        ovf_reg   <= 1'b0;
      end else if (en && rise) begin
        if (count_reg == {CNT_W{1'b1}}) ovf_reg <= 1'b1;
        else count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rosc_odometer_sequencer.sv
// Stress/measure sequencer for a bank of ring oscillators: stresses the masked
// channels, then settles, measures and reports each masked channel in turn.
module rosc_odometer_sequencer
  import rosc_odo_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int DIV_W = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ac_dc,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [WIN_W-1:0] stress_len,
  input  logic [WIN_W-1:0] win_len,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [N_CH-1:0]  rosc_out,
  output logic [N_CH-1:0]  en_power_rosc,
  output logic [N_CH-1:0]  en_rosc,
  output logic             meas_stress,
  output logic             ac_stress_clk,
  output logic [N_CH-1:0]  sel,
  output logic             busy,
  output logic             cnt_valid,
  output logic [CH_W-1:0]  cnt_ch,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cnt_ovf,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIN_W-1:0] timer_reg;
  logic [CH_W-1:0]  ch_reg, next_ch;
  logic             next_found;
  logic             ac_dc_reg, ac_clk_reg, done_reg;
  logic [N_CH-1:0]  mask_reg, ch_onehot;
  logic [WIN_W-1:0] stress_len_reg, win_len_reg;
  logic [DIV_W-1:0] clk_div_reg, div_cnt_reg;
  logic             stress_last, settle_last, meas_last, measuring, finish_run, accept;
  logic [CNT_W-1:0] count;
  logic             ovf;

  assign accept      = (state_reg == IDLE) && start && !abort;
  assign stress_last = (stress_len_reg == '0) || (timer_reg == stress_len_reg - WIN_W'(1));
  assign settle_last = (timer_reg == WIN_W'(SETTLE_CYC - 1));
  assign meas_last   = (timer_reg == win_len_reg - WIN_W'(1));
  assign measuring   = (state_reg == SETTLE) || (state_reg == MEAS) || (state_reg == REPORT);
  assign ch_onehot   = N_CH'(1) << ch_reg;

  // Lowest masked channel above the current one (or from 0 straight after stress).
  always_comb begin
    int search_from;
    next_found  = 1'b0;
    next_ch     = '0;
    search_from = (state_reg == REPORT) ? int'(ch_reg) + 1 : 0;
    for (int i = 0; i < N_CH; i++) begin
      if (!next_found && i >= search_from && mask_reg[i]) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    finish_run = 1'b0;
    case (state_reg)
      IDLE:   if (start) state_next = STRESS;
      STRESS: if (stress_last) begin
        state_next = next_found ? SETTLE : IDLE;
        finish_run = !next_found;
      end
      SETTLE: if (settle_last) state_next = (win_len_reg == '0) ? REPORT : MEAS;
      MEAS:   if (meas_last) state_next = REPORT;
      REPORT: begin
        state_next = next_found ? SETTLE : IDLE;
        finish_run = !next_found;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      finish_run = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      ch_reg         <= '0;
      ac_dc_reg      <= 1'b0;
      ac_clk_reg     <= 1'b0;
      done_reg       <= 1'b0;
      mask_reg       <= '0;
      stress_len_reg <= '0;
      win_len_reg    <= '0;
      clk_div_reg    <= '0;
      div_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= (state_next != state_reg || state_reg == IDLE) ? '0 : timer_reg + WIN_W'(1);
      done_reg  <= finish_run;
      if (accept) begin
        ac_dc_reg      <= ac_dc;
        mask_reg       <= ch_mask;
        stress_len_reg <= stress_len;
        win_len_reg    <= win_len;
        clk_div_reg    <= clk_div;
        ac_clk_reg     <= 1'b0;
        div_cnt_reg    <= '0;
      end else if (state_reg == STRESS) begin
        if (div_cnt_reg == clk_div_reg) begin
          div_cnt_reg <= '0;
          ac_clk_reg  <= ~ac_clk_reg;
        end else begin
          div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
      end
      if (state_next == SETTLE && state_reg != SETTLE) ch_reg <= next_ch;
    end
  end

  always_comb begin
    en_power_rosc = '0;
    en_rosc       = '0;
    sel           = '0;
    meas_stress   = 1'b0;
    ac_stress_clk = 1'b0;
    cnt_valid     = 1'b0;
    cnt_ch        = '0;
    cnt_val       = '0;
    cnt_ovf       = 1'b0;
    busy          = (state_reg != IDLE);
    done          = done_reg;
    if (state_reg == STRESS) begin
      en_power_rosc = mask_reg;
      en_rosc       = mask_reg;
      ac_stress_clk = ac_dc_reg ? ac_clk_reg : 1'b1;
    end else if (measuring) begin
      en_power_rosc = ch_onehot;
      en_rosc       = ch_onehot;
      sel           = ch_onehot;
      meas_stress   = 1'b1;
    end
    if (state_reg == REPORT) begin
      cnt_valid = 1'b1;
      cnt_ch    = ch_reg;
      cnt_val   = count;
      cnt_ovf   = ovf;
    end
  end

  rosc_edge_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .din   (|(rosc_out & ch_onehot & {N_CH{measuring}})),
    .clr   (state_reg == SETTLE),
    .en    (state_reg == MEAS),
    .count (count),
    .ovf   (ovf)
  );

endmodule

// File: tb/tb_rosc_odometer_sequencer.sv
// Directed bench: a 16-bit and a 4-bit counter instance share one stimulus stream.
module tb_rosc_odometer_sequencer;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, ac_dc = 1'b0;
  logic [2:0]  ch_mask = '0;
  logic [15:0] stress_len = '0, win_len = '0;
  logic [7:0]  clk_div = '0;
  logic [2:0]  rosc_out = '0;

  logic [2:0]  en_power_rosc, en_rosc, sel;
  logic        meas_stress, ac_stress_clk, busy, cnt_valid, cnt_ovf, done;
  logic [1:0]  cnt_ch;
  logic [15:0] cnt_val;
  logic [2:0]  en_power_rosc4, en_rosc4, sel4;
  logic        meas_stress4, ac_stress_clk4, busy4, cnt_valid4, cnt_ovf4, done4;
  logic [1:0]  cnt_ch4;
  logic [3:0]  cnt_val4;

  int tests_run = 0, tests_failed = 0;

  always #5 clk = ~clk;
  always #40 rosc_out[0] = ~rosc_out[0];
  always #60 rosc_out[1] = ~rosc_out[1];
  always #40 rosc_out[2] = ~rosc_out[2];

  rosc_odometer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ac_dc(ac_dc), .ch_mask(ch_mask),
    .stress_len(stress_len), .win_len(win_len), .clk_div(clk_div), .rosc_out(rosc_out),
    .en_power_rosc(en_power_rosc), .en_rosc(en_rosc), .meas_stress(meas_stress),
    .ac_stress_clk(ac_stress_clk), .sel(sel), .busy(busy), .cnt_valid(cnt_valid),
    .cnt_ch(cnt_ch), .cnt_val(cnt_val), .cnt_ovf(cnt_ovf), .done(done)
  );

  rosc_odometer_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ac_dc(ac_dc), .ch_mask(ch_mask),
    .stress_len(stress_len), .win_len(win_len), .clk_div(clk_div), .rosc_out(rosc_out),
    .en_power_rosc(en_power_rosc4), .en_rosc(en_rosc4), .meas_stress(meas_stress4),
    .ac_stress_clk(ac_stress_clk4), .sel(sel4), .busy(busy4), .cnt_valid(cnt_valid4),
    .cnt_ch(cnt_ch4), .cnt_val(cnt_val4), .cnt_ovf(cnt_ovf4), .done(done4)
  );

  wire [32:0] all_out  = {en_power_rosc, en_rosc, meas_stress, ac_stress_clk, sel, busy,
                          cnt_valid, cnt_ch, cnt_val, cnt_ovf, done};
  wire [20:0] all_out4 = {en_power_rosc4, en_rosc4, meas_stress4, ac_stress_clk4, sel4, busy4,
                          cnt_valid4, cnt_ch4, cnt_val4, cnt_ovf4, done4};

  // Event monitor, sampled on the falling edge; stats_clr restarts the tallies.
  logic        stats_clr = 1'b0;
  int          cyc = 0, n_rep = 0, n_done = 0, stress_cyc = 0, n_tog = 0, bad_int = 0;
  int          last_tog = -1, sel_bad = 0;
  logic        ac_prev = 1'b0;
  logic [1:0]  rep_ch  [8];
  logic [15:0] rep_val [8];
  logic        rep_ovf [8];
  logic [3:0]  rep4_val = '0;
  logic        rep4_ovf = 1'b0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    ac_prev <= ac_stress_clk;
    if (stats_clr) begin
      n_rep <= 0; n_done <= 0; stress_cyc <= 0; n_tog <= 0; bad_int <= 0;
      last_tog <= -1; sel_bad <= 0;
    end else begin
      if (busy && !meas_stress) stress_cyc <= stress_cyc + 1;
      if (ac_stress_clk != ac_prev) begin
        n_tog    <= n_tog + 1;
        last_tog <= cyc;
        if (last_tog >= 0 && cyc - last_tog != 3) bad_int <= bad_int + 1;
      end
      if (cnt_valid && n_rep < 8) begin
        rep_ch[n_rep]  <= cnt_ch;
        rep_val[n_rep] <= cnt_val;
        rep_ovf[n_rep] <= cnt_ovf;
        n_rep <= n_rep + 1;
        $display("[TB] report ch=%0d val=%0d ovf=%0d", cnt_ch, cnt_val, cnt_ovf);
      end
      if (cnt_valid4) begin
        rep4_val <= cnt_val4;
        rep4_ovf <= cnt_ovf4;
      end
      if (done) begin
        n_done <= n_done + 1;
        $display("[TB] done at cycle %0d", cyc);
      end
      if (meas_stress && ($countones(sel) != 1 || en_rosc != sel || en_power_rosc != sel))
        sel_bad <= sel_bad + 1;
      if (!meas_stress && sel != 3'b000) sel_bad <= sel_bad + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests_run++;
    assert (obs >= lo && obs <= hi) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    @(negedge clk);
    #1 stats_clr = 1'b0;
    step(1);
  endtask

  task automatic run(input logic ac, input logic [2:0] m, input int slen, input int wlen,
                     input int div);
    ac_dc = ac; ch_mask = m; stress_len = 16'(slen); win_len = 16'(wlen); clk_div = 8'(div);
    start = 1'b1;
    step(1);
    start = 1'b0;
    $display("[TB] start ac=%0d mask=%b stress=%0d win=%0d div=%0d", ac, m, slen, wlen, div);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && n_done == 0; i++) step(1);
    check({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
    step(2);
  endtask

  initial begin
    int k;
    // Reset state
    step(3);
    check("reset_outputs", {all_out4, all_out}, 64'd0);
    rst = 1'b0;
    step(2);
    check("idle_outputs", {all_out4, all_out}, 64'd0);

    // DC run over channels 0 and 2, with input changes after START
    clear_stats();
    run(1'b0, 3'b101, 10, 100, 0);
    check("dc_stress_en", {en_power_rosc, en_rosc, meas_stress, ac_stress_clk, busy, sel},
          {3'b101, 3'b101, 1'b0, 1'b1, 1'b1, 3'b000});
    ch_mask = 3'b010; win_len = 16'd5; ac_dc = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("dc", 2000);
    check("dc_stress_cycles", 64'(stress_cyc), 64'd10);
    check("dc_reports", 64'(n_rep), 64'd2);
    check("dc_first_ch", 64'(rep_ch[0]), 64'd0);
    check_range("dc_first_val", int'(rep_val[0]), 12, 13);
    check("dc_second_ch", 64'(rep_ch[1]), 64'd2);
    check_range("dc_second_val", int'(rep_val[1]), 12, 13);
    check("dc_done_count", 64'(n_done), 64'd1);
    check("dc_sel_onehot", 64'(sel_bad), 64'd0);
    check("dc_idle_after", {all_out4, all_out}, 64'd0);

    // AC stress with empty mask: toggle spacing and immediate completion
    clear_stats();
    run(1'b1, 3'b000, 12, 50, 2);
    wait_done("ac", 200);
    check("ac_toggles", 64'(n_tog), 64'd4);
    check("ac_toggle_spacing", 64'(bad_int), 64'd0);
    check("ac_stress_cycles", 64'(stress_cyc), 64'd12);
    check("mask0_no_reports", 64'(n_rep), 64'd0);
    check("mask0_done_count", 64'(n_done), 64'd1);

    // Saturation on the 4-bit instance, exact count on the 16-bit one
    clear_stats();
    run(1'b0, 3'b001, 2, 200, 0);
    wait_done("sat", 1000);
    check("sat_wide_val", {rep_ovf[0], rep_val[0]}, {1'b0, 16'd25});
    check("sat_narrow_val", {rep4_ovf, rep4_val}, {1'b1, 4'd15});

    // Zero-length window
    clear_stats();
    run(1'b0, 3'b110, 3, 0, 0);
    wait_done("win0", 200);
    check("win0_reports", 64'(n_rep), 64'd2);
    check("win0_ch1", {rep_ch[0], rep_ovf[0], rep_val[0]}, {2'd1, 1'b0, 16'd0});
    check("win0_ch2", {rep_ch[1], rep_ovf[1], rep_val[1]}, {2'd2, 1'b0, 16'd0});

    // START during the run, then ABORT together with START in MEAS of channel 1
    clear_stats();
    run(1'b0, 3'b111, 3, 50, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (k = 0; k < 500 && sel != 3'b010; k++) step(1);
    check("abort_reached_ch1", {sel, 1'b0}, {3'b010, 1'b0});
    step(6);
    check("abort_in_meas", {meas_stress, cnt_valid, busy}, 3'b101);
    abort = 1'b1; start = 1'b1;
    step(1);
    abort = 1'b0; start = 1'b0;
    check("abort_outputs", {all_out4, all_out}, 64'd0);
    step(3);
    check("abort_stays_idle", {all_out4, all_out}, 64'd0);
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_reports", 64'(n_rep), 64'd1);

    // Reset during STRESS, then a fresh run on channel 1
    clear_stats();
    run(1'b1, 3'b101, 20, 40, 1);
    step(5);
    rst = 1'b1;
    step(1);
    check("rst_outputs", {all_out4, all_out}, 64'd0);
    rst = 1'b0;
    step(1);
    clear_stats();
    run(1'b0, 3'b010, 4, 48, 0);
    wait_done("post_rst", 500);
    check("post_rst_reports", 64'(n_rep), 64'd1);
    check("post_rst_val", {rep_ch[0], rep_ovf[0], rep_val[0]}, {2'd1, 1'b0, 16'd4});
    check("post_rst_done", 64'(n_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
